// File: rtl/tx_pingpong_ctrl.sv
// tx_pingpong_ctrl
//    Ping-pong scheduler for the two halves of the TX buffer (half = RAM
//    address MSB). Grants a free half to the packet producer (pkt_decode)
//    and hands completed halves to the consumer (usb_slavefifo) in strict
//    alternation, along with a registered packet length.
//
// Ports
//    clk        mclk, all logic on the rising edge
//    rst_n      synchronous reset, active-low
//    wr_req     producer requests a half (level)
//    wr_grant   producer owns half wr_bank (level, until wr_done)
//    wr_bank    granted half, RAM write-address MSB; holds after release
//    wr_done    one-cycle pulse, packet in the granted half complete
//    wr_len     words written, sampled with wr_done
//    tx_start   one-cycle pulse, consumer should send half tx_bank
//    tx_bank    half being sent, RAM read-address MSB
//    tx_len     words to send
//    tx_done    one-cycle pulse, consumer finished the half
//    full_cnt   halves in FULL or SENDING (0..2)
//    err_proto  sticky protocol-error flag, cleared only by reset
//
// Per-half state
//    state   | meaning
//    FREE    | no content, may be granted to the producer
//    FILLING | granted, producer is writing
//    FULL    | holds a complete packet waiting to be sent
//    SENDING | consumer is streaming it out

module tx_pingpong_ctrl #(
   parameter int ADDR_NBIT = 8,
   parameter int LEN_NBIT  = ADDR_NBIT + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_req,
   output logic                wr_grant,
   output logic                wr_bank,
   input  logic                wr_done,
   input  logic [LEN_NBIT-1:0] wr_len,
   output logic                tx_start,
   output logic                tx_bank,
   output logic [LEN_NBIT-1:0] tx_len,
   input  logic                tx_done,
   output logic [1:0]          full_cnt,
   output logic                err_proto
);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2,
      SENDING = 2'd3
   } half_state_t;

   localparam logic [LEN_NBIT-1:0] MAX_LEN = LEN_NBIT'(1) << ADDR_NBIT;

   half_state_t         half_q [2];
   half_state_t         half_d [2];
   logic [LEN_NBIT-1:0] len_q  [2];
   logic [LEN_NBIT-1:0] len_d  [2];

   logic                wr_sel_q, wr_sel_d;
   logic                rd_sel_q, rd_sel_d;
   logic                grant_d, bank_d, start_d, tx_bank_d, err_d;
   logic [LEN_NBIT-1:0] tx_len_d;
   logic [1:0]          full_cnt_d;
   logic                any_sending;
   logic                loaded0, loaded1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         half_q[0] <= FREE;
         half_q[1] <= FREE;
         len_q[0]  <= '0;
         len_q[1]  <= '0;
         wr_sel_q  <= 1'b0;
         rd_sel_q  <= 1'b0;
         wr_grant  <= 1'b0;
         wr_bank   <= 1'b0;
         tx_start  <= 1'b0;
         tx_bank   <= 1'b0;
         tx_len    <= '0;
         full_cnt  <= 2'd0;
         err_proto <= 1'b0;
      end else begin
         half_q[0] <= half_d[0];
         half_q[1] <= half_d[1];
         len_q[0]  <= len_d[0];
         len_q[1]  <= len_d[1];
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         wr_grant  <= grant_d;
         wr_bank   <= bank_d;
         tx_start  <= start_d;
         tx_bank   <= tx_bank_d;
         tx_len    <= tx_len_d;
         full_cnt  <= full_cnt_d;
         err_proto <= err_d;
      end
   end

   // The four events below touch disjoint halves whenever they coincide
   // (grant needs FREE, wr_done owns the FILLING half, send needs FULL and
   // nothing SENDING, tx_done needs SENDING), so they are applied
   // independently without priority.
   always_comb begin
      half_d[0]  = half_q[0];
      half_d[1]  = half_q[1];
      len_d[0]   = len_q[0];
      len_d[1]   = len_q[1];
      wr_sel_d   = wr_sel_q;
      rd_sel_d   = rd_sel_q;
      grant_d    = wr_grant;
      bank_d     = wr_bank;
      start_d    = 1'b0;
      tx_bank_d  = tx_bank;
      tx_len_d   = tx_len;
      err_d      = err_proto;
      full_cnt_d = 2'd0;
      loaded0    = 1'b0;
      loaded1    = 1'b0;

      any_sending = (half_q[0] == SENDING) || (half_q[1] == SENDING);

      if (wr_req && !wr_grant && (half_q[wr_sel_q] == FREE)) begin
         grant_d          = 1'b1;
         bank_d           = wr_sel_q;
         half_d[wr_sel_q] = FILLING;
      end

      if (wr_done) begin
         if (wr_grant) begin
            grant_d = 1'b0;
            if (wr_len == '0) begin
               // empty packet: hand the same half back, pointer stays
               half_d[wr_bank] = FREE;
            end else begin
               half_d[wr_bank] = FULL;
               wr_sel_d        = ~wr_sel_q;
               if (wr_len > MAX_LEN) begin
                  len_d[wr_bank] = MAX_LEN;
                  err_d          = 1'b1;
               end else begin
                  len_d[wr_bank] = wr_len;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (!any_sending && (half_q[rd_sel_q] == FULL)) begin
         start_d          = 1'b1;
         tx_bank_d        = rd_sel_q;
         tx_len_d         = len_q[rd_sel_q];
         half_d[rd_sel_q] = SENDING;
      end

      // the SENDING half is always the one last announced on tx_bank
      if (tx_done) begin
         if (any_sending) begin
            half_d[tx_bank] = FREE;
            rd_sel_d        = ~rd_sel_q;
         end else begin
            err_d = 1'b1;
         end
      end

      loaded0    = (half_d[0] == FULL) || (half_d[0] == SENDING);
      loaded1    = (half_d[1] == FULL) || (half_d[1] == SENDING);
      full_cnt_d = {1'b0, loaded0} + {1'b0, loaded1};
   end

endmodule
